request_demux_bridge: RTL and testbench

- Request-side counterpart of the bridge response fan-in tree: routes one master TCDM-style request port (req/gnt) to one of N_SLAVE slave request ports by address field.
- Tracks outstanding transactions so responses stay in order once merged by the response tree.
- Unmapped targets get a locally generated error response on a dedicated response leg, which feeds slot N_SLAVE of the response tree.

---
 rtl/request_demux_bridge_if.sv | 47 ++++
 rtl/request_demux_bridge.sv | 110 +++++++++++
 tb/tb_request_demux_bridge.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/request_demux_bridge_if.sv
// Request-side bus bundle of the demux bridge: master request leg, fanned-out
// slave request legs, slave grant/response-valid feedback and the error response leg.
interface request_demux_bridge_if #(
    parameter int N_SLAVE    = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int AUX_WIDTH  = 8
);
    logic                  data_req_i;
    logic [ADDR_WIDTH-1:0] data_add_i;
    logic                  data_wen_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic [BE_WIDTH-1:0]   data_be_i;
    logic [AUX_WIDTH-1:0]  data_aux_i;
    logic                  data_gnt_o;

    logic [N_SLAVE-1:0]    data_req_o;
    logic [ADDR_WIDTH-1:0] data_add_o;
    logic                  data_wen_o;
    logic [DATA_WIDTH-1:0] data_wdata_o;
    logic [BE_WIDTH-1:0]   data_be_o;
    logic [AUX_WIDTH-1:0]  data_aux_o;
    logic [N_SLAVE-1:0]    data_gnt_i;
    logic [N_SLAVE-1:0]    data_r_valid_i;

    logic                  err_r_valid_o;
    logic [DATA_WIDTH-1:0] err_r_rdata_o;
    logic                  err_r_opc_o;
    logic [AUX_WIDTH-1:0]  err_r_aux_o;

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i,
        input  data_gnt_o,
        input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o,
        output data_gnt_i, data_r_valid_i,
        input  err_r_valid_o, err_r_rdata_o, err_r_opc_o, err_r_aux_o
    );

    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_aux_i,
        output data_gnt_o,
        output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o,
        input  data_gnt_i, data_r_valid_i,
        output err_r_valid_o, err_r_rdata_o, err_r_opc_o, err_r_aux_o
    );
endinterface

// File: rtl/request_demux_bridge.sv
// Routes one master request port to N_SLAVE slave ports by address field, keeps
// outstanding traffic on a single target so responses stay ordered, and answers unmapped targets locally.
module request_demux_bridge #(
    parameter int                    N_SLAVE    = 16,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BE_WIDTH   = DATA_WIDTH / 8,
    parameter int                    AUX_WIDTH  = 8,
    parameter int                    SEL_LSB    = 12,
    parameter int                    MAX_OUT    = 4,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 'hBADACCE5
) (
    input  logic                 clk,
    input  logic                 rst,
    request_demux_bridge_if.slave bus
);
    localparam int SEL_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
    localparam int CUR_W = $clog2(N_SLAVE + 1);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CUR_W-1:0] ERR_T   = CUR_W'(N_SLAVE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0]     cnt_q;
    logic [CUR_W-1:0]     cur_q;
    logic [CUR_W-1:0]     tgt;
    logic                 err_valid_q;
    logic                 err_opc_q;
    logic [DATA_WIDTH-1:0] err_rdata_q;
    logic [AUX_WIDTH-1:0] err_aux_q;

    logic                 stall;
    logic                 is_err;
    logic                 slv_gnt;
    logic                 gnt;
    logic                 hs;
    logic                 rsp;
    logic                 dec;
    logic [N_SLAVE-1:0]   req_vec;

    // Target index N_SLAVE is the error pseudo-slave for selects beyond the last port.
    if (N_SLAVE == 1) begin : g_single
        assign tgt = '0;
    end else begin : g_multi
        logic [SEL_W-1:0] sel;
        assign sel = bus.data_add_i[SEL_LSB +: SEL_W];
        assign tgt = (CUR_W'(sel) >= ERR_T) ? ERR_T : CUR_W'(sel);
    end

    // Switching target is only safe once every outstanding response has returned.
    assign stall  = ~rst & ((cnt_q == CNT_MAX) | ((cnt_q != '0) & (tgt != cur_q)));
    assign is_err = (tgt == ERR_T);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req_vec = '0;
        slv_gnt = 1'b0;
        rsp     = err_valid_q;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (tgt == CUR_W'(i)) begin
                req_vec[i] = bus.data_req_i & ~stall;
                slv_gnt    = req_vec[i] & bus.data_gnt_i[i];
            end
            if (cur_q == CUR_W'(i)) begin
                rsp = bus.data_r_valid_i[i];
            end
        end
    end

    assign gnt = is_err ? (bus.data_req_i & ~stall) : slv_gnt;
    assign hs  = bus.data_req_i & gnt;
    assign dec = rsp & (cnt_q != '0);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cur_q       <= '0;
            err_valid_q <= 1'b0;
            err_opc_q   <= 1'b0;
            err_rdata_q <= '0;
            err_aux_q   <= '0;
        end else begin
            if (hs) begin
                cur_q <= tgt;
            end
            case ({hs, dec})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            // Error leg is idle-zero between single-cycle pulses.
            err_valid_q <= hs & is_err;
            err_opc_q   <= hs & is_err;
            err_rdata_q <= (hs & is_err) ? ERR_DATA : '0;
            err_aux_q   <= (hs & is_err) ? bus.data_aux_i : '0;
        end
    end

    assign bus.data_req_o    = req_vec;
    assign bus.data_gnt_o    = gnt;
    assign bus.data_add_o    = bus.data_add_i;
    assign bus.data_wen_o    = bus.data_wen_i;
    assign bus.data_wdata_o  = bus.data_wdata_i;
    assign bus.data_be_o     = bus.data_be_i;
    assign bus.data_aux_o    = bus.data_aux_i;
    assign bus.err_r_valid_o = err_valid_q;
    assign bus.err_r_rdata_o = err_rdata_q;
    assign bus.err_r_opc_o   = err_opc_q;
    assign bus.err_r_aux_o   = err_aux_q;
endmodule

// File: tb/tb_request_demux_bridge.sv
// Bench for request_demux_bridge: directed scenarios plus randomized traffic,
// checked every cycle against a queue-of-outstanding-targets reference model.
module tb_request_demux_bridge;
    localparam int N       = 12;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int BW      = 4;
    localparam int XW      = 8;
    localparam int SEL_LSB = 12;
    localparam int MAX_OUT = 4;
    localparam logic [DW-1:0] ERR_DATA = 32'hBADACCE5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    request_demux_bridge_if #(
        .N_SLAVE(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .AUX_WIDTH(XW)
    ) bus ();

    request_demux_bridge #(
        .N_SLAVE(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .AUX_WIDTH(XW),
        .SEL_LSB(SEL_LSB), .MAX_OUT(MAX_OUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: targets of in-flight transactions, oldest first, and the error pulse due now.
    int             q[$];
    bit             m_err_v;
    logic [XW-1:0]  m_err_aux;

    logic           obs_gnt;
    logic [N-1:0]   obs_req;
    logic           obs_ev;
    logic [DW-1:0]  obs_erd;
    logic [XW-1:0]  obs_eaux;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit req, input logic [AW-1:0] addr,
                        input logic [XW-1:0] aux, input logic [N-1:0] gv, input logic [N-1:0] rv);
        int            t;
        bit            stall;
        bit            hs;
        bit            rsp;
        logic [N-1:0]  one;
        logic [N-1:0]  er;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        logic          wen;
        wd  = $urandom;
        be  = BW'($urandom);
        wen = 1'($urandom);
        @(negedge clk);
        rst                = r;
        bus.data_req_i     = req;
        bus.data_add_i     = addr;
        bus.data_wen_i     = wen;
        bus.data_wdata_i   = wd;
        bus.data_be_i      = be;
        bus.data_aux_i     = aux;
        bus.data_gnt_i     = gv;
        bus.data_r_valid_i = rv;
        #1;
        t = int'(addr[SEL_LSB +: 4]);
        if (t >= N) t = N;
        stall = !r && (q.size() == MAX_OUT || (q.size() != 0 && q[0] != t));
        one   = 1;
        er    = (req && !stall && t < N) ? (one << t) : '0;
        hs    = req && !stall && (t == N || gv[t]);
        rsp   = (q.size() != 0) && ((q[0] == N) ? m_err_v : rv[q[0]]);

        obs_gnt  = bus.data_gnt_o;
        obs_req  = bus.data_req_o;
        obs_ev   = bus.err_r_valid_o;
        obs_erd  = bus.err_r_rdata_o;
        obs_eaux = bus.err_r_aux_o;

        check("req_o",   bus.data_req_o,    er);
        check("gnt_o",   bus.data_gnt_o,    hs);
        check("add_o",   bus.data_add_o,    addr);
        check("wen_o",   bus.data_wen_o,    wen);
        check("wdata_o", bus.data_wdata_o,  wd);
        check("be_o",    bus.data_be_o,     be);
        check("aux_o",   bus.data_aux_o,    aux);
        check("err_v",   bus.err_r_valid_o, m_err_v);
        check("err_rd",  bus.err_r_rdata_o, m_err_v ? ERR_DATA : '0);
        check("err_opc", bus.err_r_opc_o,   m_err_v);
        check("err_aux", bus.err_r_aux_o,   m_err_v ? m_err_aux : '0);

        @(posedge clk);
        if (r) begin
            q.delete();
            m_err_v   = 1'b0;
            m_err_aux = '0;
        end else begin
            if (rsp) void'(q.pop_front());
            if (hs) q.push_back(t);
            m_err_v = hs && (t == N);
            if (hs && t == N) m_err_aux = aux;
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int sel);
        return AW'(sel) << SEL_LSB;
    endfunction

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    initial begin
        m_err_v   = 1'b0;
        m_err_aux = '0;
        step(1, 0, '0, '0, '0, '0);
        step(1, 0, '0, '0, '0, '0);

        // Single read to slave 3, response next cycle, then idle again.
        step(0, 1, 32'h0000_3000, 8'h11, bit_of(3), '0);
        check("t1_req", obs_req, 12'h008);
        check("t1_gnt", obs_gnt, 1'b1);
        step(0, 0, '0, '0, '0, bit_of(3));
        step(0, 1, addr_of(4), 8'h12, bit_of(4), '0);
        check("t1_idle_gnt", obs_gnt, 1'b1);
        step(0, 0, '0, '0, '0, bit_of(4));

        // Fill to MAX_OUT on slave 5, then the next request stalls.
        for (int i = 0; i < MAX_OUT; i++) step(0, 1, addr_of(5), 8'h20, bit_of(5), '0);
        step(0, 1, addr_of(5), 8'h21, bit_of(5), '0);
        check("t2_full_gnt", obs_gnt, 1'b0);
        check("t2_full_req", obs_req, '0);
        step(0, 1, addr_of(5), 8'h22, bit_of(5), bit_of(5));
        step(0, 1, addr_of(5), 8'h23, bit_of(5), '0);
        check("t2_refill_gnt", obs_gnt, 1'b1);
        for (int i = 0; i < MAX_OUT; i++) step(0, 0, '0, '0, '0, bit_of(5));

        // Target switch waits for the old target to drain.
        step(0, 1, addr_of(1), 8'h30, bit_of(1), '0);
        step(0, 1, addr_of(1), 8'h31, bit_of(1), '0);
        step(0, 1, addr_of(2), 8'h32, bit_of(2), '0);
        check("t3_stall", obs_gnt, 1'b0);
        step(0, 1, addr_of(2), 8'h32, bit_of(2), bit_of(1));
        step(0, 1, addr_of(2), 8'h32, bit_of(2), bit_of(1));
        check("t3_last_stall", obs_gnt, 1'b0);
        step(0, 1, addr_of(2), 8'h32, bit_of(2), '0);
        check("t3_switch", obs_gnt, 1'b1);
        step(0, 0, '0, '0, '0, bit_of(2));

        // Unmapped select 14 answered by the local error leg.
        step(0, 1, 32'h0000_E000, 8'h5A, '0, '0);
        check("t4_gnt", obs_gnt, 1'b1);
        check("t4_req", obs_req, '0);
        step(0, 0, '0, '0, '0, '0);
        check("t4_ev",  obs_ev, 1'b1);
        check("t4_erd", obs_erd, ERR_DATA);
        check("t4_aux", obs_eaux, 8'h5A);
        step(0, 1, 32'h0000_F000, 8'hA1, '0, '0);
        step(0, 1, 32'h0000_C000, 8'hA2, '0, '0);
        step(0, 0, '0, '0, '0, '0);
        check("t4_b2b_aux", obs_eaux, 8'hA2);
        step(0, 0, '0, '0, '0, '0);

        // Simultaneous handshake and response, then a stray response from another slave.
        for (int i = 0; i < 3; i++) step(0, 1, addr_of(2), 8'h40, bit_of(2), '0);
        step(0, 1, addr_of(2), 8'h41, bit_of(2), bit_of(2));
        step(0, 0, '0, '0, '0, bit_of(7));
        step(0, 1, addr_of(2), 8'h42, bit_of(2), '0);
        check("t5_fourth", obs_gnt, 1'b1);
        step(0, 1, addr_of(2), 8'h43, bit_of(2), '0);
        check("t5_full", obs_gnt, 1'b0);

        // Reset discards outstanding tracking and a pending error pulse.
        step(1, 0, '0, '0, '0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, addr_of(6), 8'h50, bit_of(6), '0);
        step(1, 0, '0, '0, '0, '0);
        step(0, 1, addr_of(9), 8'h51, bit_of(9), '0);
        check("t6_after_rst", obs_gnt, 1'b1);
        step(0, 0, '0, '0, '0, bit_of(9));
        step(0, 1, 32'h0000_D000, 8'h52, '0, '0);
        step(1, 0, '0, '0, '0, '0);
        step(0, 0, '0, '0, '0, bit_of(6));
        check("t6_err_cleared", obs_ev, 1'b0);

        // Randomized traffic with occasional resets.
        begin
            int sel = 0;
            for (int c = 0; c < 3000; c++) begin
                logic [AW-1:0] a;
                logic [N-1:0]  gv;
                logic [N-1:0]  rv;
                bit            r;
                if ($urandom_range(0, 3) == 0) sel = $urandom_range(0, 15);
                a  = ($urandom & 32'hFFFF_0FFF) | addr_of(sel);
                gv = N'($urandom) | (($urandom_range(0, 1) == 1) ? bit_of(sel % N) : '0);
                rv = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
                if (q.size() != 0 && q[0] < N && $urandom_range(0, 2) == 0) rv = rv | bit_of(q[0]);
                r  = ($urandom_range(0, 199) == 0);
                step(r, $urandom_range(0, 3) != 0, a, XW'($urandom), gv, rv);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
